function_unit_pipe: RTL

- Parametrised, registered successor to the datapath function unit: WIDTH-bit ALU, shifter and optional iterative multiplier behind a valid/ready handshake.
- Sits between operand fetch (A/B buses) and the register-file write-back.
- Adds full, correct Z/N/V/C flag generation, logical shifts by SH, and a multi-cycle MUL state machine with back-pressure.

---
 rtl/fu_pkg.sv | 35 +++
 rtl/fu_shifter.sv | 37 +++
 rtl/function_unit_pipe.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fu_pkg.sv
// Shared definitions for the pipelined function unit: opcode map and FSM encoding.
package fu_pkg;

  // Function-select opcodes, shared with the control decoder.
  localparam logic [4:0] FS_MOVA  = 5'b00000;
  localparam logic [4:0] FS_INCA  = 5'b00001;
  localparam logic [4:0] FS_ADD   = 5'b00010;
  localparam logic [4:0] FS_ADDC  = 5'b00011;
  localparam logic [4:0] FS_ADDNB = 5'b00100;
  localparam logic [4:0] FS_SUB   = 5'b00101;
  localparam logic [4:0] FS_DECA  = 5'b00110;
  localparam logic [4:0] FS_MOVA2 = 5'b00111;
  localparam logic [4:0] FS_AND   = 5'b01000;
  localparam logic [4:0] FS_OR    = 5'b01010;
  localparam logic [4:0] FS_XOR   = 5'b01100;
  localparam logic [4:0] FS_NOTA  = 5'b01110;
  localparam logic [4:0] FS_MOVB  = 5'b10000;
  localparam logic [4:0] FS_SHR   = 5'b10100;
  localparam logic [4:0] FS_SHL   = 5'b11000;
  localparam logic [4:0] FS_MUL   = 5'b11100;

  // Multiply sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } fu_state_e;

  // True for opcodes that route through the (WIDTH+1)-bit adder.
  function automatic logic fu_is_adder_op(input logic [4:0] op);
    return (op == FS_INCA) || (op == FS_ADD) || (op == FS_ADDC) ||
           (op == FS_ADDNB) || (op == FS_SUB) || (op == FS_DECA);
  endfunction

endpackage

// File: rtl/fu_shifter.sv
// Combinational WIDTH-bit logical barrel shifter (left/right) with carry-out
// equal to the last bit shifted out.
module fu_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   amt_i,
  input  logic             left_i,
  output logic [WIDTH-1:0] data_o,
  output logic             carry_o
);

  logic [SHW-1:0] amt;
  logic [WIDTH:0] ext_l;
  logic [WIDTH:0] ext_r;

  // Reduce the amount modulo WIDTH, then shift through a one-bit extension
  // that catches the last bit out (zero when the amount is zero).
  always_comb begin
    if ({1'b0, amt_i} >= (SHW+1)'(WIDTH)) begin
      amt = amt_i - SHW'(WIDTH);
    end else begin
      amt = amt_i;
    end
    ext_l = {1'b0, data_i} << amt;
    ext_r = {data_i, 1'b0} >> amt;
    if (left_i) begin
      data_o  = ext_l[WIDTH-1:0];
      carry_o = ext_l[WIDTH];
    end else begin
      data_o  = ext_r[WIDTH:1];
      carry_o = ext_r[0];
    end
  end

endmodule

// File: rtl/function_unit_pipe.sv
// Registered function unit: ALU, logical shifter and optional iterative
// multiplier behind a valid/ready handshake, with Z/N/V/C flags.
module function_unit_pipe
  import fu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SHW    = $clog2(WIDTH),
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   sh,
  input  logic [4:0]       fs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             z,
  output logic             n,
  output logic             v,
  output logic             c,
  output logic             busy
);

  fu_state_e state_q, state_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] f_q;
  logic             z_q, n_q, v_q, c_q;

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [SHW-1:0]     cnt_q;

  logic             accept;
  logic             is_mul;
  logic             mul_last;

  logic [WIDTH-1:0] opb;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_f;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH-1:0] sh_f;
  logic             sh_c;

  assign accept   = in_valid && in_ready;
  assign is_mul   = (MUL_EN != 0) && (fs == FS_MUL);
  assign mul_last = (state_q == MUL) && (cnt_q == SHW'(WIDTH-1));

  fu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .data_i  (b),
    .amt_i   (sh),
    .left_i  (fs == FS_SHL),
    .data_o  (sh_f),
    .carry_o (sh_c)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: IDLE -> MUL for WIDTH cycles -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mul) state_d = MUL;
      MUL:     if (mul_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: accept only when idle and the output slot is free or draining.
  always_comb begin
    in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    busy     = (state_q == MUL);
  end

  // Adder operand selection; A-1 is A plus all-ones so carry reflects A!=0.
  always_comb begin
    opb = '0;
    cin = 1'b0;
    case (fs)
      FS_INCA:  cin = 1'b1;
      FS_ADD:   opb = b;
      FS_ADDC:  begin opb = b;  cin = 1'b1; end
      FS_ADDNB: opb = ~b;
      FS_SUB:   begin opb = ~b; cin = 1'b1; end
      FS_DECA:  opb = '1;
      default:  ;
    endcase
    sum = {1'b0, a} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
  end

  // Single-cycle result and carry/overflow selection.
  always_comb begin
    alu_f = a;
    alu_c = 1'b0;
    alu_v = 1'b0;
    if (fu_is_adder_op(fs)) begin
      alu_f = sum[WIDTH-1:0];
      alu_c = sum[WIDTH];
      alu_v = (a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end else begin
      case (fs)
        FS_AND:  alu_f = a & b;
        FS_OR:   alu_f = a | b;
        FS_XOR:  alu_f = a ^ b;
        FS_NOTA: alu_f = ~a;
        FS_MOVB: alu_f = b;
        FS_SHR,
        FS_SHL:  begin alu_f = sh_f; alu_c = sh_c; end
        default: ;
      endcase
    end
  end

  // One shift-add step of the multiplier.
  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Multiplier operand/accumulator registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (accept && is_mul) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == MUL) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + SHW'(1);
    end
  end

  // Output slot: single-cycle results load on accept, the product loads on
  // the final MUL step and is published one cycle later from DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      f_q         <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      c_q         <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid_q <= 1'b1;
      f_q         <= alu_f;
      z_q         <= (alu_f == '0);
      n_q         <= alu_f[WIDTH-1];
      v_q         <= alu_v;
      c_q         <= alu_c;
    end else if (mul_last) begin
      f_q         <= acc_d[WIDTH-1:0];
      z_q         <= (acc_d[WIDTH-1:0] == '0);
      n_q         <= acc_d[WIDTH-1];
      v_q         <= 1'b0;
      c_q         <= |acc_d[2*WIDTH-1:WIDTH];
    end else if (state_q == DONE) begin
      out_valid_q <= 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign z         = z_q;
  assign n         = n_q;
  assign v         = v_q;
  assign c         = c_q;

endmodule
